// File: rtl/main_if.sv
// Hall sensor, control and gate-driver signal bundle for the BLDC commutation controller.
interface main_if;
   logic       H1;
   logic       H2;
   logic       H3;
   logic       LOW;
   logic [3:0] D;
   logic       A_OUT;
   logic       AA_OUT;
   logic       B_OUT;
   logic       BB_OUT;
   logic       C_OUT;
   logic       CC_OUT;

   // Stimulus / sensor side drives Hall, coast and duty; observes gates.
   modport master (
      output H1, H2, H3, LOW, D,
      input  A_OUT, AA_OUT, B_OUT, BB_OUT, C_OUT, CC_OUT
   );

   // Controller side.
   modport slave (
      input  H1, H2, H3, LOW, D,
      output A_OUT, AA_OUT, B_OUT, BB_OUT, C_OUT, CC_OUT
   );
endinterface

// File: rtl/main.sv
// Six-step BLDC commutation controller: Hall sync/decode, dead time on every
// commutation change, and 4-bit PWM on the active high-side switch.
module main #(
   parameter int unsigned DEAD_CYCLES  = 2,
   parameter int unsigned PWM_PRESCALE = 1
) (
   input  logic  clk,
   input  logic  rst,
   main_if.slave bus
);

   localparam int unsigned DEAD_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

   logic [2:0]        r_s1;
   logic [2:0]        r_s2;
   logic [2:0]        r_hall;
   logic [DEAD_W-1:0] r_dead;
   logic [PRE_W-1:0]  r_pre;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_duty;
   logic [2:0]        r_hi;
   logic [2:0]        r_lo;

   logic [2:0]        w_hall_in;
   logic              w_commit;
   logic              w_pre_wrap;
   logic              w_pwm;
   logic              w_dead_active;
   logic [2:0]        w_hi_sel;
   logic [2:0]        w_lo_sel;

   assign w_hall_in     = {bus.H3, bus.H2, bus.H1};
   assign w_commit      = (r_s2 != r_hall);
   assign w_pre_wrap    = (r_pre == PRE_W'(PWM_PRESCALE - 1));
   assign w_pwm         = (r_cnt < r_duty);
   assign w_dead_active = (r_dead != '0);

   // Two-stage synchronizer for the asynchronous Hall inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_hall_in;
         r_s2 <= r_s1;
      end
   end

   // Commit a changed Hall state and (re)start the dead-time countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hall <= '0;
         r_dead <= '0;
      end else if (w_commit) begin
         r_hall <= r_s2;
         r_dead <= DEAD_W'(DEAD_CYCLES);
      end else if (w_dead_active) begin
         r_dead <= r_dead - DEAD_W'(1);
      end
   end

   // PWM prescaler and period counter; duty is sampled only at period start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre  <= '0;
         r_cnt  <= '0;
         r_duty <= '0;
      end else if (w_pre_wrap) begin
         r_pre <= '0;
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_cnt == CNT_W'(15)) begin
            r_duty <= bus.D;
         end
      end else begin
         r_pre <= r_pre + PRE_W'(1);
      end
   end

   // Commutation table: one-hot {C,B,A} high-side and low-side selection.
   always_comb begin
      w_hi_sel = 3'b000;
      w_lo_sel = 3'b000;
      unique case (r_hall)
         3'b001:  begin w_hi_sel = 3'b001; w_lo_sel = 3'b010; end
         3'b101:  begin w_hi_sel = 3'b001; w_lo_sel = 3'b100; end
         3'b100:  begin w_hi_sel = 3'b010; w_lo_sel = 3'b100; end
         3'b110:  begin w_hi_sel = 3'b010; w_lo_sel = 3'b001; end
         3'b010:  begin w_hi_sel = 3'b100; w_lo_sel = 3'b001; end
         3'b011:  begin w_hi_sel = 3'b100; w_lo_sel = 3'b010; end
         default: begin w_hi_sel = 3'b000; w_lo_sel = 3'b000; end
      endcase
   end

   // Registered gate outputs; coast and dead time force every switch off.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (bus.LOW || w_dead_active) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         r_hi <= w_hi_sel & {3{w_pwm}};
         r_lo <= w_lo_sel;
      end
   end

   assign bus.A_OUT  = r_hi[0];
   assign bus.B_OUT  = r_hi[1];
   assign bus.C_OUT  = r_hi[2];
   assign bus.AA_OUT = r_lo[0];
   assign bus.BB_OUT = r_lo[1];
   assign bus.CC_OUT = r_lo[2];

endmodule

// File: tb/tb_main.sv
// Self-checking bench for the BLDC commutation controller: directed scenarios
// plus randomized Hall/duty/coast/reset traffic against an edge-index model.
module tb_main;

   localparam int unsigned DEAD = 2;
   localparam int unsigned P    = 1;
   localparam int          BIG  = 100000;

   logic clk;
   logic rst;

   main_if bus ();

   main #(.DEAD_CYCLES(DEAD), .PWM_PRESCALE(P)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks;
   int n_fail;

   // Model state, expressed as edge counts rather than register contents.
   int         m;        // edges since the last reset edge
   logic [2:0] hin1;     // Hall input seen one edge ago
   logic [2:0] hin2;     // Hall input seen two edges ago
   logic [2:0] comm;     // committed Hall code
   int         since;    // edges since the last commit
   logic [3:0] duty;     // duty in force for the current PWM period
   logic [5:0] exp_v;    // expected {A,AA,B,BB,C,CC}

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, req, $time);
      end
   endtask

   function automatic logic [5:0] gates();
      return {bus.A_OUT, bus.AA_OUT, bus.B_OUT, bus.BB_OUT, bus.C_OUT, bus.CC_OUT};
   endfunction

   // Phase indices 0=A 1=B 2=C; vector order {A,AA,B,BB,C,CC}.
   function automatic logic [5:0] pattern(input logic [2:0] code, input logic pwm);
      logic [5:0] v;
      int hp;
      int lp;
      v  = '0;
      hp = -1;
      lp = -1;
      case (code)
         3'b001: begin hp = 0; lp = 1; end
         3'b101: begin hp = 0; lp = 2; end
         3'b100: begin hp = 1; lp = 2; end
         3'b110: begin hp = 1; lp = 0; end
         3'b010: begin hp = 2; lp = 0; end
         3'b011: begin hp = 2; lp = 1; end
         default: ;
      endcase
      if (hp >= 0) begin
         v[5 - 2*hp] = pwm;
         v[4 - 2*lp] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic bad_overlap(input logic [5:0] g);
      logic [2:0] hi;
      logic [2:0] lo;
      hi = {g[5], g[3], g[1]};
      lo = {g[4], g[2], g[0]};
      return ((hi & lo) != 3'b000) || ($countones(hi) > 1) || ($countones(lo) > 1);
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      logic [2:0] newc;
      int         cnt;
      if (rst) begin
         m     = 0;
         hin1  = '0;
         hin2  = '0;
         comm  = '0;
         since = BIG;
         duty  = '0;
         exp_v = '0;
      end else begin
         cnt   = (m / P) % 16;
         exp_v = (bus.LOW || since < DEAD) ? 6'b0 : pattern(comm, 1'(cnt < int'(duty)));
         m++;
         newc = hin2;
         hin2 = hin1;
         hin1 = {bus.H3, bus.H2, bus.H1};
         if (newc != comm) since = 0;
         else if (since < BIG) since++;
         comm = newc;
         if ((m % P == 0) && ((m / P) % 16 == 0)) duty = bus.D;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("gates", 32'(gates()), 32'(exp_v));
      chk("exclusive", 32'(bad_overlap(gates())), 32'd0);
   endtask

   task automatic set_hall(input logic [2:0] h);
      {bus.H3, bus.H2, bus.H1} = h;
   endtask

   task automatic align_period();
      while (m % (16 * P) != 0) step();
   endtask

   // One full PWM period, counting A high-side and B low-side on-cycles.
   task automatic window(output int a_cnt, output int bb_cnt);
      a_cnt  = 0;
      bb_cnt = 0;
      for (int i = 0; i < 16 * int'(P); i++) begin
         step();
         a_cnt  += int'(bus.A_OUT);
         bb_cnt += int'(bus.BB_OUT);
      end
   endtask

   function automatic logic [2:0] rot_code(input int cyc);
      int t;
      logic h1, h2, h3;
      t  = (cyc * 20) % 6000;
      h1 = (t < 2000) || (t >= 5000);
      h2 = (t >= 3000);
      h3 = (t >= 1000) && (t < 4000);
      return {h3, h2, h1};
   endfunction

   initial begin
      int a_cnt;
      int bb_cnt;
      int dwell;
      int idx;
      logic [2:0] seq [6];
      n_checks = 0;
      n_fail   = 0;
      seq = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};

      // Reset with a valid code and nonzero duty present.
      rst = 1'b1;
      bus.LOW = 1'b0;
      bus.D   = 4'd11;
      set_hall(3'b001);
      repeat (3) step();
      chk("reset_gates", 32'(gates()), 32'd0);

      rst = 1'b0;
      for (int i = 0; i < 3 + int'(DEAD); i++) begin
         step();
         chk("startup_low", 32'(gates()), 32'd0);
      end
      step();
      chk("startup_bb", 32'(bus.BB_OUT), 32'd1);

      // Duty sweep with Hall 001 steady.
      repeat (40) step();
      align_period();
      window(a_cnt, bb_cnt);
      chk("duty11_a", 32'(a_cnt), 32'(11 * P));
      chk("duty11_bb", 32'(bb_cnt), 32'(16 * P));
      bus.D = 4'd0;
      window(a_cnt, bb_cnt);
      window(a_cnt, bb_cnt);
      chk("duty0_a", 32'(a_cnt), 32'd0);
      bus.D = 4'd15;
      window(a_cnt, bb_cnt);
      window(a_cnt, bb_cnt);
      chk("duty15_a", 32'(a_cnt), 32'(15 * P));

      // Mid-period duty change only takes effect at the next period.
      bus.D = 4'd11;
      window(a_cnt, bb_cnt);
      a_cnt = 0;
      for (int i = 0; i < 16 * int'(P); i++) begin
         if (i == 5) bus.D = 4'd4;
         step();
         a_cnt += int'(bus.A_OUT);
      end
      chk("duty_hold_11", 32'(a_cnt), 32'(11 * P));
      window(a_cnt, bb_cnt);
      chk("duty_next_4", 32'(a_cnt), 32'(4 * P));

      // Two full electrical rotations at D=11.
      bus.D = 4'd11;
      for (int i = 0; i < 600; i++) begin
         set_hall(rot_code(i));
         step();
      end

      // Invalid codes coast; a valid code resumes after dead time.
      set_hall(3'b000);
      repeat (20) step();
      chk("invalid_000", 32'(gates()), 32'd0);
      set_hall(3'b111);
      repeat (20) step();
      chk("invalid_111", 32'(gates()), 32'd0);
      set_hall(3'b100);
      repeat (3 + int'(DEAD) + 20) step();
      chk("resume_cc", 32'(bus.CC_OUT), 32'd1);

      // Coast asserts and releases on the very next edge.
      bus.LOW = 1'b1;
      step();
      chk("low_forced", 32'(gates()), 32'd0);
      bus.LOW = 1'b0;
      step();
      chk("low_release_cc", 32'(bus.CC_OUT), 32'd1);

      // Randomized rotation with glitches, invalid codes, coast, duty and reset.
      idx   = 2;
      dwell = 0;
      for (int i = 0; i < 2000; i++) begin
         rst = ($urandom_range(0, 999) < 3);
         if ($urandom_range(0, 19) == 0) bus.LOW = ~bus.LOW;
         if ($urandom_range(0, 29) == 0) bus.D = 4'($urandom);
         if (dwell == 0) begin
            case ($urandom_range(0, 19))
               0:       set_hall(3'b000);
               1:       set_hall(3'b111);
               2:       set_hall(3'($urandom));
               3:       begin idx = (idx + 5) % 6; set_hall(seq[idx]); end
               default: begin idx = (idx + 1) % 6; set_hall(seq[idx]); end
            endcase
            dwell = int'($urandom_range(1, 25));
         end
         dwell--;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
